// File: rtl/avl_resp_pkg.sv
// avl_resp_pkg: shared types and defaults for the Avalon-MM memory responder
package avl_resp_pkg;
  typedef enum logic [1:0] {INIT, IDLE, STALL, ACK} state_t;
  localparam int DEF_ADDR_W       = 26;
  localparam int DEF_DATA_W       = 128;
  localparam int DEF_MEM_AW       = 8;
  localparam int DEF_INIT_CYCLES  = 16;
  localparam int DEF_STALL_CYCLES = 2;
  localparam int DEF_READ_LAT     = 4;
  localparam int CNT_W            = 16;
endpackage

// File: rtl/avl_resp_rdpipe.sv
// avl_resp_rdpipe: LAT-deep valid+data delay line with async clear
module avl_resp_rdpipe #(
  parameter int LAT = 4,
  parameter int W   = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         v [LAT];
  logic [W-1:0] d [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        v[i] <= 1'b0;
        d[i] <= '0;
      end
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];
endmodule

// File: rtl/avl_mem_responder.sv
// avl_mem_responder: Avalon-MM stand-in for a DDR3 local interface with
// calibration delay, wait states, fixed read latency and an aliased RAM
module avl_mem_responder import avl_resp_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_AW       = DEF_MEM_AW,
  parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int READ_LAT     = DEF_READ_LAT
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  output logic              local_init_done,
  output logic              avl_waitrequest_n,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [DATA_W-1:0] avl_writedata,
  input  logic              avl_burstbegin,
  output logic              avl_readdatavalid,
  output logic [DATA_W-1:0] avl_readdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic              proto_err
);
  localparam int TW = $clog2(INIT_CYCLES + STALL_CYCLES + 2);
  state_t            state, state_n;
  logic [TW-1:0]     tmr, tmr_n;
  logic              req, acc, rd_acc, wr_acc, both_err, stall_err;
  logic [MEM_AW-1:0] idx;
  logic [CNT_W-1:0]  burst_count;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic              unused_ok;
  assign req      = avl_read | avl_write;
  assign acc      = state == ACK;
  assign rd_acc   = acc & avl_read & ~avl_write;
  assign wr_acc   = acc & avl_write & ~avl_read;
  assign both_err = acc & avl_read & avl_write;
  assign idx      = avl_address[MEM_AW-1:0];
  assign unused_ok = &{1'b0, avl_address[ADDR_W-1:MEM_AW], burst_count};
  always_comb begin
    state_n   = state;
    tmr_n     = tmr + 1'b1;
    stall_err = 1'b0;
    unique case (state)
      INIT: if (tmr == TW'(INIT_CYCLES)) begin
        state_n = IDLE;
        tmr_n   = '0;
      end
      IDLE: begin
        tmr_n   = '0;
        state_n = req ? (STALL_CYCLES == 0 ? ACK : STALL) : IDLE;
      end
      STALL: if (!req) begin
        state_n   = IDLE;
        stall_err = 1'b1;
        tmr_n     = '0;
      end else if (tmr == TW'(STALL_CYCLES - 1)) begin
        state_n = ACK;
        tmr_n   = '0;
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state             <= INIT;
      tmr               <= '0;
      local_init_done   <= 1'b0;
      avl_waitrequest_n <= 1'b0;
      wr_count          <= '0;
      rd_count          <= '0;
      proto_err         <= 1'b0;
      burst_count       <= '0;
    end else begin
      state             <= state_n;
      tmr               <= tmr_n;
      local_init_done   <= state_n != INIT;
      avl_waitrequest_n <= state_n == ACK;
      wr_count          <= wr_count + CNT_W'(wr_acc);
      rd_count          <= rd_count + CNT_W'(rd_acc);
      proto_err         <= proto_err | stall_err | both_err;
      burst_count       <= burst_count + CNT_W'(state == IDLE & req & avl_burstbegin);
    end
  end
  // RAM contents deliberately survive reset, like real DRAM behind a controller
  always_ff @(posedge iCLK) if (wr_acc) mem[idx] <= avl_writedata;
  avl_resp_rdpipe #(.LAT(READ_LAT), .W(DATA_W)) u_rdpipe (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .in_valid (rd_acc),
    .in_data  (mem[idx]),
    .out_valid(avl_readdatavalid),
    .out_data (avl_readdata)
  );
endmodule
